// File: rtl/gmii_rx_capture.sv
// gmii_rx_capture
//   Samples a GMII receive interface, strips preamble and SFD, and writes the
//   frame payload (FCS included) into the RX FIFO write port. The last byte of
//   each frame carries fifo_eof, and fifo_err marks a bad frame: PHY error,
//   runt, giant, or bytes lost to a full FIFO.
//
// Ports
//   gmii_rx_clk   : receive clock, all logic on the rising edge
//   sys_rst       : synchronous active-high reset
//   gmii_rx_dv    : PHY receive data valid
//   gmii_rx_er    : PHY receive error
//   gmii_rxd      : PHY receive data byte
//   fifo_full     : FIFO cannot accept a write this cycle
//   fifo_we       : FIFO write strobe (registered)
//   fifo_dout     : payload byte (registered)
//   fifo_eof      : with fifo_we, last byte of the frame
//   fifo_err      : with fifo_eof, frame is bad
//   frame_ok_cnt  : good frames delivered (wraps)
//   frame_err_cnt : bad or dropped frames (wraps)
module gmii_rx_capture #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input  logic             gmii_rx_clk,
  input  logic             sys_rst,
  input  logic             gmii_rx_dv,
  input  logic             gmii_rx_er,
  input  logic [7:0]       gmii_rxd,
  input  logic             fifo_full,
  output logic             fifo_we,
  output logic [7:0]       fifo_dout,
  output logic             fifo_eof,
  output logic             fifo_err,
  output logic [CNT_W-1:0] frame_ok_cnt,
  output logic [CNT_W-1:0] frame_err_cnt
);

  localparam logic [7:0]       PRE_BYTE = 8'h55;
  localparam logic [7:0]       SFD_BYTE = 8'hD5;
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  // Stage-1 copies of the PHY pins; the FSM only ever looks at these.
  logic             dv_q;
  logic             er_q;
  logic [7:0]       rxd_q;

  state_t           state_reg;
  logic [7:0]       hold_reg;
  logic             hold_valid_reg;
  logic [CNT_W-1:0] len_reg;
  logic             err_reg;
  logic             ovf_reg;

  // Verdict for the frame whose last byte is currently in the hold register.
  logic frame_bad;
  assign frame_bad = err_reg | ovf_reg | (len_reg < MIN_C) | (len_reg > MAX_C);

  always_ff @(posedge gmii_rx_clk) begin
    if (sys_rst) begin
      dv_q           <= 1'b0;
      er_q           <= 1'b0;
      rxd_q          <= 8'h00;
      state_reg      <= IDLE;
      hold_reg       <= 8'h00;
      hold_valid_reg <= 1'b0;
      len_reg        <= '0;
      err_reg        <= 1'b0;
      ovf_reg        <= 1'b0;
      fifo_we        <= 1'b0;
      fifo_dout      <= 8'h00;
      fifo_eof       <= 1'b0;
      fifo_err       <= 1'b0;
      frame_ok_cnt   <= '0;
      frame_err_cnt  <= '0;
    end else begin
      dv_q  <= gmii_rx_dv;
      er_q  <= gmii_rx_er;
      rxd_q <= gmii_rxd;

      // Write strobes are single-cycle pulses; dout holds its last value.
      fifo_we  <= 1'b0;
      fifo_eof <= 1'b0;
      fifo_err <= 1'b0;

      case (state_reg)
        IDLE: begin
          // er_q without dv_q (carrier extension / false carrier) is ignored.
          if (dv_q) begin
            if (rxd_q == PRE_BYTE) begin
              state_reg <= PRE;
            end else if (rxd_q == SFD_BYTE) begin
              state_reg      <= DATA;
              len_reg        <= '0;
              err_reg        <= 1'b0;
              ovf_reg        <= 1'b0;
              hold_valid_reg <= 1'b0;
            end else begin
              state_reg <= DROP;
            end
          end
        end

        PRE: begin
          if (!dv_q) begin
            state_reg <= IDLE;
          end else if (rxd_q == SFD_BYTE) begin
            state_reg      <= DATA;
            len_reg        <= '0;
            err_reg        <= 1'b0;
            ovf_reg        <= 1'b0;
            hold_valid_reg <= 1'b0;
          end else if (rxd_q != PRE_BYTE) begin
            state_reg <= DROP;
          end
        end

        DATA: begin
          if (dv_q) begin
            // One-byte hold lets the final byte be tagged with eof once
            // dv drops, without knowing the frame length in advance.
            hold_reg       <= rxd_q;
            hold_valid_reg <= 1'b1;
            if (hold_valid_reg) begin
              if (!fifo_full) begin
                fifo_we   <= 1'b1;
                fifo_dout <= hold_reg;
              end else begin
                ovf_reg <= 1'b1;
              end
            end
            if (len_reg != '1) begin
              len_reg <= len_reg + 1'b1;
            end
            if (er_q) begin
              err_reg <= 1'b1;
            end
          end else begin
            state_reg      <= IDLE;
            hold_valid_reg <= 1'b0;
            if (hold_valid_reg && !fifo_full) begin
              fifo_we   <= 1'b1;
              fifo_dout <= hold_reg;
              fifo_eof  <= 1'b1;
              fifo_err  <= frame_bad;
              if (frame_bad) begin
                frame_err_cnt <= frame_err_cnt + 1'b1;
              end else begin
                frame_ok_cnt <= frame_ok_cnt + 1'b1;
              end
            end else begin
              // Empty frame (SFD straight into dv low) or eof byte lost to a
              // full FIFO: the frame never completes downstream.
              frame_err_cnt <= frame_err_cnt + 1'b1;
            end
          end
        end

        DROP: begin
          if (!dv_q) begin
            state_reg     <= IDLE;
            frame_err_cnt <= frame_err_cnt + 1'b1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_capture.sv
// Testbench for gmii_rx_capture: directed table rows, hand-written corner
// sequences (bad preamble + 1-cycle gap, reset mid-frame) and random frames,
// all checked cycle by cycle against a frame-level reference model.
module tb_gmii_rx_capture;

  localparam int TB_MIN = 64;
  localparam int TB_MAX = 1518;

  logic        clk;
  logic        sys_rst;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic [7:0]  gmii_rxd;
  logic        fifo_full;
  logic        fifo_we;
  logic [7:0]  fifo_dout;
  logic        fifo_eof;
  logic        fifo_err;
  logic [15:0] frame_ok_cnt;
  logic [15:0] frame_err_cnt;

  gmii_rx_capture dut (
    .gmii_rx_clk   (clk),
    .sys_rst       (sys_rst),
    .gmii_rx_dv    (gmii_rx_dv),
    .gmii_rx_er    (gmii_rx_er),
    .gmii_rxd      (gmii_rxd),
    .fifo_full     (fifo_full),
    .fifo_we       (fifo_we),
    .fifo_dout     (fifo_dout),
    .fifo_eof      (fifo_eof),
    .fifo_err      (fifo_err),
    .frame_ok_cnt  (frame_ok_cnt),
    .frame_err_cnt (frame_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One entry per clock: values driven just after a rising edge.
  typedef struct {
    logic       dv;
    logic       er;
    logic       rst;
    logic       full;
    logic [7:0] rxd;
  } stim_t;

  typedef struct {
    logic [7:0] d;
    logic       eof;
    logic       err;
  } wr_t;

  typedef struct {
    int start;    // stim index of first payload byte
    int plen;
    bit er_any;
    bit drop;
    int rst_at;   // payload index carrying a reset pulse, -1 none
  } frm_t;

  typedef struct {
    string name;
    int    pre_len;
    int    plen;
    int    er_pos;
    int    full_from;
    int    full_len;
    bit    full_eof;
    int    exp_writes;
    int    exp_eofs;
    bit    exp_err;
    int    exp_dok;
    int    exp_derr;
  } row_t;

  stim_t       stim[$];
  frm_t        frames[$];
  wr_t         exp_wr[int];
  logic [15:0] exp_ok;
  logic [15:0] exp_err;
  int          total;
  int          bad;
  int          obs_writes;
  int          obs_eofs;
  logic        obs_last_err;

  task automatic check(input string nm, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic push(input logic dv, input logic er, input logic rst, input logic [7:0] d);
    stim_t s;
    s.dv = dv; s.er = er; s.rst = rst; s.full = 1'b0; s.rxd = d;
    stim.push_back(s);
  endtask

  task automatic add_frame(input int pre_len, input int plen, input int er_pos,
                           input int gap, input bit rnd, input int rst_at);
    frm_t f;
    logic [7:0] d;
    for (int i = 0; i < pre_len; i++) push(1'b1, 1'b0, 1'b0, 8'h55);
    push(1'b1, 1'b0, 1'b0, 8'hD5);
    f.start  = stim.size();
    f.plen   = plen;
    f.er_any = (er_pos >= 0 && er_pos < plen);
    f.drop   = 1'b0;
    f.rst_at = rst_at;
    for (int i = 0; i < plen; i++) begin
      d = rnd ? 8'($urandom_range(0, 255)) : 8'(i);
      push(1'b1, (i == er_pos), (i == rst_at), d);
    end
    for (int i = 0; i < gap; i++) push(1'b0, 1'b0, 1'b0, 8'h00);
    frames.push_back(f);
  endtask

  task automatic add_bad_frame(input int n, input int gap);
    frm_t f;
    push(1'b1, 1'b0, 1'b0, 8'h55);
    push(1'b1, 1'b0, 1'b0, 8'h55);
    push(1'b1, 1'b0, 1'b0, 8'h5A);
    for (int i = 0; i < n; i++) push(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
    for (int i = 0; i < gap; i++) push(1'b0, 1'b0, 1'b0, 8'h00);
    f.start = 0; f.plen = 0; f.er_any = 1'b0; f.drop = 1'b1; f.rst_at = -1;
    frames.push_back(f);
  endtask

  task automatic pad();
    for (int i = 0; i < 6; i++) push(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic set_full(input int idx);
    stim_t s;
    s = stim[idx];
    s.full = 1'b1;
    stim[idx] = s;
  endtask

  // Frame-level model: a payload byte driven in cycle t must appear at cycle
  // t+3 unless the FIFO was full in cycle t+2 (when that write is decided).
  task automatic build_expected();
    frm_t f;
    int   t;
    bit   ovf;
    bit   fbad;
    wr_t  w;
    for (int k = 0; k < frames.size(); k++) begin
      f = frames[k];
      if (f.drop || f.plen == 0) begin
        exp_err++;
      end else begin
        ovf = 1'b0;
        for (int i = 0; i < f.plen; i++) begin
          t = f.start + i;
          if (f.rst_at >= 0 && i > f.rst_at - 3) break;
          if (i < f.plen - 1) begin
            if (!stim[t + 2].full) begin
              w.d = stim[t].rxd; w.eof = 1'b0; w.err = 1'b0;
              exp_wr[t + 3] = w;
            end else begin
              ovf = 1'b1;
            end
          end else begin
            fbad = f.er_any | ovf | (f.plen < TB_MIN) | (f.plen > TB_MAX);
            if (!stim[t + 2].full) begin
              w.d = stim[t].rxd; w.eof = 1'b1; w.err = fbad;
              exp_wr[t + 3] = w;
              if (fbad) exp_err++; else exp_ok++;
            end else begin
              exp_err++;
            end
          end
        end
        if (f.rst_at >= 0) begin
          // Reset clears the counters; the rest of the frame is then junk.
          exp_ok  = 16'd0;
          exp_err = (f.plen - 1 > f.rst_at) ? 16'd1 : 16'd0;
        end
      end
    end
  endtask

  task automatic play(input string tag);
    obs_writes   = 0;
    obs_eofs     = 0;
    obs_last_err = 1'b0;
    for (int c = 0; c < stim.size(); c++) begin
      @(posedge clk);
      #1;
      sys_rst    = stim[c].rst;
      gmii_rx_dv = stim[c].dv;
      gmii_rx_er = stim[c].er;
      gmii_rxd   = stim[c].rxd;
      fifo_full  = stim[c].full;
      @(negedge clk);
      if (c > 0 && stim[c - 1].rst) begin
        check({tag, " rst we"}, fifo_we, 0);
        check({tag, " rst dout"}, fifo_dout, 0);
        check({tag, " rst eof"}, fifo_eof, 0);
        check({tag, " rst okcnt"}, frame_ok_cnt, 0);
        check({tag, " rst errcnt"}, frame_err_cnt, 0);
      end
      if (exp_wr.exists(c)) begin
        check($sformatf("%s we c%0d", tag, c), fifo_we, 1);
        check($sformatf("%s dout c%0d", tag, c), fifo_dout, exp_wr[c].d);
        check($sformatf("%s eof c%0d", tag, c), fifo_eof, exp_wr[c].eof);
        if (exp_wr[c].eof) check($sformatf("%s err c%0d", tag, c), fifo_err, exp_wr[c].err);
      end else begin
        check($sformatf("%s we c%0d", tag, c), fifo_we, 0);
      end
      if (fifo_we) obs_writes++;
      if (fifo_we && fifo_eof) begin
        obs_eofs++;
        obs_last_err = fifo_err;
      end
    end
    check({tag, " ok_cnt"}, frame_ok_cnt, exp_ok);
    check({tag, " err_cnt"}, frame_err_cnt, exp_err);
    $display("%s: writes=%0d eofs=%0d ok=%0d err=%0d", tag, obs_writes, obs_eofs,
             frame_ok_cnt, frame_err_cnt);
    stim.delete();
    frames.delete();
    exp_wr.delete();
  endtask

  row_t        rows[10];
  logic [15:0] ok0;
  logic [15:0] err0;
  logic [15:0] dlt;
  int          st;
  int          sel;
  int          plen;
  int          erp;

  initial begin
    total = 0;
    bad   = 0;

    rows[0] = '{"good64",     7, 64,   -1, -1, 0, 1'b0, 64,   1, 1'b0, 1, 0};
    rows[1] = '{"rxer10",     7, 64,   10, -1, 0, 1'b0, 64,   1, 1'b1, 0, 1};
    rows[2] = '{"runt8",      7, 8,    -1, -1, 0, 1'b0, 8,    1, 1'b1, 0, 1};
    rows[3] = '{"giant1519",  7, 1519, -1, -1, 0, 1'b0, 1519, 1, 1'b1, 0, 1};
    rows[4] = '{"max1518",    7, 1518, -1, -1, 0, 1'b0, 1518, 1, 1'b0, 1, 0};
    rows[5] = '{"short_pre",  0, 64,   -1, -1, 0, 1'b0, 64,   1, 1'b0, 1, 0};
    rows[6] = '{"len63",      7, 63,   -1, -1, 0, 1'b0, 63,   1, 1'b1, 0, 1};
    rows[7] = '{"sfd_only",   7, 0,    -1, -1, 0, 1'b0, 0,    0, 1'b0, 0, 1};
    rows[8] = '{"full3mid",   7, 64,   -1, 30, 3, 1'b0, 61,   1, 1'b1, 0, 1};
    rows[9] = '{"full_eof",   7, 64,   -1, -1, 0, 1'b1, 63,   0, 1'b0, 0, 1};

    sys_rst    = 1'b1;
    gmii_rx_dv = 1'b0;
    gmii_rx_er = 1'b0;
    gmii_rxd   = 8'h00;
    fifo_full  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset we", fifo_we, 0);
    check("reset dout", fifo_dout, 0);
    check("reset eof", fifo_eof, 0);
    check("reset err", fifo_err, 0);
    check("reset okcnt", frame_ok_cnt, 0);
    check("reset errcnt", frame_err_cnt, 0);
    @(posedge clk);
    #1 sys_rst = 1'b0;
    exp_ok  = 16'd0;
    exp_err = 16'd0;

    // Directed table rows.
    for (int r = 0; r < 10; r++) begin
      ok0  = frame_ok_cnt;
      err0 = frame_err_cnt;
      add_frame(rows[r].pre_len, rows[r].plen, rows[r].er_pos, 3, 1'b0, -1);
      pad();
      st = frames[0].start;
      for (int k = 0; k < rows[r].full_len; k++) set_full(st + rows[r].full_from + k + 2);
      if (rows[r].full_eof) set_full(st + rows[r].plen + 1);
      build_expected();
      play(rows[r].name);
      check({rows[r].name, " writes"}, obs_writes, rows[r].exp_writes);
      check({rows[r].name, " eofs"}, obs_eofs, rows[r].exp_eofs);
      if (rows[r].exp_eofs > 0) check({rows[r].name, " eof_err"}, obs_last_err, rows[r].exp_err);
      dlt = frame_ok_cnt - ok0;
      check({rows[r].name, " d_ok"}, dlt, rows[r].exp_dok);
      dlt = frame_err_cnt - err0;
      check({rows[r].name, " d_err"}, dlt, rows[r].exp_derr);
    end

    // Bad preamble dropped, then a good frame after a single idle cycle.
    ok0  = frame_ok_cnt;
    err0 = frame_err_cnt;
    add_bad_frame(5, 1);
    add_frame(7, 64, -1, 3, 1'b0, -1);
    pad();
    build_expected();
    play("drop_then_good");
    check("drop_then_good writes", obs_writes, 64);
    check("drop_then_good eofs", obs_eofs, 1);
    check("drop_then_good eof_err", obs_last_err, 0);
    dlt = frame_ok_cnt - ok0;
    check("drop_then_good d_ok", dlt, 1);
    dlt = frame_err_cnt - err0;
    check("drop_then_good d_err", dlt, 1);

    // Reset pulse on payload byte 20, then a clean frame.
    add_frame(7, 64, -1, 2, 1'b0, 20);
    add_frame(7, 64, -1, 3, 1'b0, -1);
    pad();
    build_expected();
    play("rst_mid");
    check("rst_mid writes", obs_writes, 18 + 64);
    check("rst_mid eofs", obs_eofs, 1);
    check("rst_mid eof_err", obs_last_err, 0);
    check("rst_mid okcnt", frame_ok_cnt, 1);
    check("rst_mid errcnt", frame_err_cnt, 1);

    // Random frames, gaps and FIFO back-pressure.
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 7) == 0) begin
        add_bad_frame($urandom_range(0, 10), $urandom_range(1, 4));
      end else begin
        sel = $urandom_range(0, 9);
        plen = (sel == 0) ? 0 : (sel == 1) ? 64 : (sel == 2) ? 63 : $urandom_range(1, 100);
        erp = ($urandom_range(0, 5) == 0 && plen > 0) ? $urandom_range(0, plen - 1) : -1;
        add_frame($urandom_range(0, 7), plen, erp, $urandom_range(1, 4), 1'b1, -1);
      end
    end
    pad();
    for (int i = 0; i < stim.size(); i++) begin
      if ($urandom_range(0, 19) == 0) set_full(i);
    end
    build_expected();
    play("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
